// File: rtl/fetch_redirect_unit.sv
// Fetch-side PC and IF/ID register. Takes the ID-stage branch/jump
// decision, computes redirect targets from the instruction in IF/ID and
// selects the next fetch address. Delay slot semantics: the instruction
// after a control transfer is always fetched and kept (no flush).
module fetch_redirect_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br,
  input  logic        is_j,
  input  logic        is_jr,
  input  logic [31:0] jr_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic        addr_err
);

  typedef struct packed {
    logic        take;
    logic [31:0] tgt;
  } redir_t;

  logic [31:0] id_pc_plus4;
  logic [31:0] btarget;
  logic [31:0] jtarget;
  logic [31:0] next_pc;
  logic        misalign;
  redir_t      redir;

  assign id_pc_plus4 = id_pc + 32'd4;
  assign id_pc8      = id_pc + 32'd8;
  assign btarget     = id_pc_plus4 + {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
  assign jtarget     = {id_pc_plus4[31:28], id_instr[25:0], 2'b00};

  // Redirect select: jr > j > branch; only a real, unstalled IF/ID entry redirects.
  always_comb begin
    redir = '0;
    if (id_valid && !stall) begin
      if (is_jr)     redir = '{take: 1'b1, tgt: jr_addr};
      else if (is_j) redir = '{take: 1'b1, tgt: jtarget};
      else if (br)   redir = '{take: 1'b1, tgt: btarget};
    end
    misalign = redir.take && (redir.tgt[1:0] != 2'b00);
    next_pc  = redir.take ? {redir.tgt[31:2], 2'b00} : pc + 32'd4;
  end

  // PC and IF/ID update; stall freezes everything including the sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= PC_RESET;
      id_instr <= NOP_WORD;
      id_pc    <= 32'h0;
      id_valid <= 1'b0;
      addr_err <= 1'b0;
    end else if (!stall) begin
      pc       <= next_pc;
      id_instr <= imem_rdata;
      id_pc    <= pc;
      id_valid <= 1'b1;
      addr_err <= addr_err | misalign;
    end
  end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Fetch-side consumer of the ID-stage branch decision. It owns the PC register and the IF/ID pipeline register.
- It computes the branch, j/jal and jr targets from the instruction held in IF/ID and selects the next PC.
- It honours the hazard unit's stall and follows MIPS single-delay-slot semantics. The instruction after a control transfer is always fetched and kept; there is no flush.

Parameters:
PC_RESET, 32'h0000_3000, PC value loaded on reset.
NOP_WORD, 32'h0000_0000, IF/ID instruction value after reset.

Ports:
clk  in  1  system clock; all registers update on the rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
stall  in  1  hazard-unit stall; freezes the PC and IF/ID.
br  in  1  branch-taken decision for the instruction in IF/ID.
is_j  in  1  IF/ID instruction is j or jal.
is_jr  in  1  IF/ID instruction is jr or jalr.
jr_addr  in  32  forwarded rs value for jr/jalr.
imem_rdata  in  32  instruction memory word at address pc.
pc  out  32  current fetch address to instruction memory.
id_instr  out  32  IF/ID instruction register.
id_pc  out  32  PC of id_instr.
id_pc8  out  32  id_pc + 8 (jal/jalr link value).
id_valid  out  1  IF/ID holds a real fetched instruction.
addr_err  out  1  sticky flag: a misaligned redirect target was seen.

Behaviour:
- Reset (reset=0, asynchronous): pc=PC_RESET, id_instr=NOP_WORD, id_pc=0, id_valid=0, addr_err=0. Reset is checked first and holds for as long as reset=0, including mid-stall or mid-redirect. After release, the first rising edge fetches PC_RESET.
- Target arithmetic (all modulo 2^32, wrap-around silent):
  - seq = pc + 4.
  - btarget = id_pc + 4 + (sign-extend id_instr[15:0] << 2).
  - jtarget = {id_pc_plus4[31:28], id_instr[25:0], 2'b00}, where id_pc_plus4 = id_pc + 4.
  - jrtarget = jr_addr.
- Redirect qualification: br, is_j and is_jr are ignored when id_valid=0.
- next_pc priority:
  1. stall: hold.
  2. is_jr: jrtarget.
  3. is_j: jtarget.
  4. br: btarget.
  5. otherwise: seq.
- When more than one of is_jr, is_j and br is 1 at once, the priority above applies; no error is raised.
- Misaligned target: if the selected redirect target has bits [1:0] != 0, pc loads the target with bits [1:0] forced to 00 and addr_err is set. addr_err stays set until reset. The seq path can never be misaligned.
- Clock edge with stall=0:
  - pc <= next_pc.
  - id_instr <= imem_rdata.
  - id_pc <= pc.
  - id_valid <= 1.
- Clock edge with stall=1:
  - pc, id_instr, id_pc and id_valid all hold.
  - br, is_j and is_jr are ignored that cycle; the same instruction re-presents them once stall drops.
  - addr_err does not change.
- Delay slot: in the cycle a redirect is accepted, pc already points at the delay-slot instruction. That instruction enters IF/ID on the same edge pc loads the target.
- id_pc8 is combinational: id_pc + 8.
- Single-cycle redirect latency: a redirect accepted at edge N makes the target appear on pc after edge N. The target instruction reaches IF/ID at edge N+1.

Test Plan:
1. Reset then run: release reset, 3 edges, stall=0, all redirects 0, imem_rdata=0x11111111 → pc = 0x3000, 0x3004, 0x3008, 0x300C. id_pc = 0x3008, id_valid=1, id_instr=0x11111111.
2. Backward branch: id_pc=0x3010, id_instr[15:0]=0xFFFC, br=1 → pc loads 0x3004 (0x3014 − 16). The delay slot at 0x3014 is latched into IF/ID with id_pc=0x3014.
3. Jump and priority: id_pc=0x3000_0000, id_instr[25:0]=0x0000_C04, is_j=1, br=1 → pc=0x3000_3010 (jump wins over branch). With is_jr=1 also set and jr_addr=0x0000_4000 → pc=0x0000_4000.
4. Stall vs branch: hold stall=1 for 2 edges with br=1 → pc, id_pc, id_instr and id_valid unchanged and no redirect taken. Drop stall → redirect taken on the next edge.
5. Misaligned jr: jr_addr=0x0000_3006, is_jr=1 → pc=0x0000_3004 and addr_err=1. addr_err stays 1 through 5 further normal cycles and clears only on reset=0.
6. Async reset mid-redirect: assert reset=0 between edges while br=1 → pc=0x3000, id_valid=0 and addr_err=0 immediately, with no clock edge needed.
